// File: rtl/pipe_add.sv
module pipe_add #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    sub,
  output logic                    out_vld,
  output logic signed [WIDTH-1:0] sum,
  output logic                    cout,
  output logic                    ovfl
);

  localparam int SW = WIDTH / STAGES;

  function automatic logic ovfl_fn(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // stage k: add slice k of the effective operands plus the carry from stage k-1
    logic                    vld_in;
    logic signed [WIDTH-1:0] a_in;
    logic signed [WIDTH-1:0] b_in;
    logic signed [WIDTH-1:0] sum_in;
    logic                    c_in;
    logic [SW:0]             slice;
    logic signed [WIDTH-1:0] sum_next;

    logic                    vld_p;
    logic signed [WIDTH-1:0] a_p;
    logic signed [WIDTH-1:0] b_p;
    logic signed [WIDTH-1:0] sum_p;
    logic                    cry_p;

    if (k == 0) begin : g_first
      assign vld_in = in_vld;
      assign a_in   = A;
      assign b_in   = sub ? ~B : B;
      assign sum_in = '0;
      assign c_in   = sub;
    end else begin : g_next
      assign vld_in = g_stage[k-1].vld_p;
      assign a_in   = g_stage[k-1].a_p;
      assign b_in   = g_stage[k-1].b_p;
      assign sum_in = g_stage[k-1].sum_p;
      assign c_in   = g_stage[k-1].cry_p;
    end

    assign slice = {1'b0, a_in[k*SW +: SW]} + {1'b0, b_in[k*SW +: SW]} + (SW+1)'(c_in);

    always_comb begin
      sum_next = sum_in;
      sum_next[k*SW +: SW] = slice[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        a_p   <= '0;
        b_p   <= '0;
        sum_p <= '0;
        cry_p <= 1'b0;
      end else begin
        vld_p <= vld_in;
        if (vld_in) begin
          a_p   <= a_in;
          b_p   <= b_in;
          sum_p <= sum_next;
          cry_p <= slice[SW];
        end
      end
    end
  end

  // output: final stage registers, overflow from the effective operand MSBs
  logic unused_ops;
  assign unused_ops = ^{g_stage[STAGES-1].a_p[WIDTH-2:0], g_stage[STAGES-1].b_p[WIDTH-2:0]};

  assign out_vld = g_stage[STAGES-1].vld_p;
  assign sum     = g_stage[STAGES-1].sum_p;
  assign cout    = g_stage[STAGES-1].cry_p;
  assign ovfl    = ovfl_fn(g_stage[STAGES-1].a_p[WIDTH-1],
                           g_stage[STAGES-1].b_p[WIDTH-1],
                           g_stage[STAGES-1].sum_p[WIDTH-1]);

endmodule

// File: tb/tb_pipe_add.sv
module tb_pipe_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        vld16, sub16, ov16, c16, o16;
  logic [15:0] a16, b16, s16;

  logic        vld8, sub8, ov1, c1, o1, ov8, c8, o8;
  logic [7:0]  a8, b8, s1, s8;

  int n_vec = 0;
  int n_err = 0;

  pipe_add #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(vld16), .A(a16), .B(b16), .sub(sub16),
    .out_vld(ov16), .sum(s16), .cout(c16), .ovfl(o16)
  );

  pipe_add #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld8), .A(a8), .B(b8), .sub(sub8),
    .out_vld(ov1), .sum(s1), .cout(c1), .ovfl(o1)
  );

  pipe_add #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld8), .A(a8), .B(b8), .sub(sub8),
    .out_vld(ov8), .sum(s8), .cout(c8), .ovfl(o8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] es, input logic ec, input logic eo);
    a16 = a; b16 = b; sub16 = s; vld16 = 1'b1;
    @(posedge clk); #1;
    vld16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; sub16 = ~s;
    repeat (2) begin
      @(posedge clk); #1;
      chk({tag, "_early_vld"}, 32'(ov16), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_vld"}, 32'(ov16), 32'd1);
    chk({tag, "_sum"}, 32'(s16), 32'(es));
    chk({tag, "_cout"}, 32'(c16), 32'(ec));
    chk({tag, "_ovfl"}, 32'(o16), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, 32'(ov16), 32'd0);
    chk({tag, "_sum_hold"}, 32'(s16), 32'(es));
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] es, input logic ec, input logic eo);
    a8 = a; b8 = b; sub8 = s; vld8 = 1'b1;
    @(posedge clk); #1;
    vld8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; sub8 = ~s;
    chk({tag, "_s1_vld"}, 32'(ov1), 32'd1);
    chk({tag, "_s1_sum"}, 32'(s1), 32'(es));
    chk({tag, "_s1_cout"}, 32'(c1), 32'(ec));
    chk({tag, "_s1_ovfl"}, 32'(o1), 32'(eo));
    chk({tag, "_s8_early"}, 32'(ov8), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_s8_early2"}, 32'(ov8), 32'd0);
    chk({tag, "_s1_drop"}, 32'(ov1), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_s8_vld"}, 32'(ov8), 32'd1);
    chk({tag, "_s8_sum"}, 32'(s8), 32'(es));
    chk({tag, "_s8_cout"}, 32'(c8), 32'(ec));
    chk({tag, "_s8_ovfl"}, 32'(o8), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_s8_drop"}, 32'(ov8), 32'd0);
  endtask

  logic        st_v [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] st_a [10] = '{16'h1000, 16'h4000, 16'hFFFF, 16'h0003, 16'hFFF0,
                             16'h7FFF, 16'h1111, 16'hABCD, 16'h0100, 16'h8001};
  logic [15:0] st_b [10] = '{16'h2000, 16'h4000, 16'hFFFF, 16'h0005, 16'h0020,
                             16'hFFFF, 16'h2222, 16'h1111, 16'h0100, 16'hFFFF};
  logic        st_s [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] st_es[10] = '{16'h3000, 16'h8000, 16'h0000, 16'hFFFE, 16'h0010,
                             16'h8000, 16'h0000, 16'hBCDE, 16'h0000, 16'h8000};
  logic        st_ec[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        st_eo[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b1;
    vld16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    vld8  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", 32'(ov16), 32'd0);
    chk("rst_sum", 32'(s16), 32'd0);
    chk("rst_cout", 32'(c16), 32'd0);
    chk("rst_ovfl", 32'(o16), 32'd0);
    chk("rst_s1_vld", 32'(ov1), 32'd0);
    chk("rst_s8_vld", 32'(ov8), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    op16("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    op16("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("sub_neg",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op16("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op16("sub_eq",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
    op16("add_neg2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op16("sub_zero", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // streaming with gaps; previous result 0xFFFF is held until the first stream result
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        vld16 = st_v[c]; a16 = st_a[c]; b16 = st_b[c]; sub16 = st_s[c];
      end else begin
        vld16 = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 3) begin
        chk($sformatf("st_vld_%0d", c - 3), 32'(ov16), 32'(st_v[c-3]));
        if (st_v[c-3]) begin
          chk($sformatf("st_sum_%0d", c - 3), 32'(s16), 32'(st_es[c-3]));
          chk($sformatf("st_cout_%0d", c - 3), 32'(c16), 32'(st_ec[c-3]));
          chk($sformatf("st_ovfl_%0d", c - 3), 32'(o16), 32'(st_eo[c-3]));
        end else begin
          chk($sformatf("st_hold_%0d", c - 3), 32'(s16), 32'(st_es[c-4]));
        end
      end else begin
        chk($sformatf("st_pre_%0d", c), 32'(ov16), 32'd0);
      end
    end

    // three operations in flight, then asynchronous reset mid-cycle
    for (int i = 1; i <= 3; i++) begin
      vld16 = 1'b1; a16 = 16'(i); b16 = 16'(i); sub16 = 1'b0;
      @(posedge clk); #1;
    end
    vld16 = 1'b0;
    chk("flight_vld", 32'(ov16), 32'd0);
    chk("flight_cout_held", 32'(c16), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(ov16), 32'd0);
    chk("midrst_sum", 32'(s16), 32'd0);
    chk("midrst_cout", 32'(c16), 32'd0);
    chk("midrst_ovfl", 32'(o16), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_vld_%0d", i), 32'(ov16), 32'd0);
      chk($sformatf("post_rst_sum_%0d", i), 32'(s16), 32'd0);
    end
    op16("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    op8("w8_ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("w8_addovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("w8_subovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("w8_subneg", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("w8_add",    8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
    op8("w8_sub90",  8'h90, 8'h20, 1'b1, 8'h70, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_add.md
# pipe_add

Parametrised, pipelined two's-complement adder/subtractor. Generalises the single-bit combinational half-adder cell to a WIDTH-bit datapath split into STAGES registered carry-ripple slices. Accepts one operation per clock with a valid flag and returns sum, carry and signed overflow a fixed STAGES cycles later. Used for score/position arithmetic where a wide combinational carry chain would limit clock rate.

## Interface

- WIDTH, 16, operand/result width in bits; WIDTH ≥ 2.
- STAGES, 4, pipeline depth; 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0. Slice width SW = WIDTH/STAGES.

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock, asynchronous assert, active-low.
- in_vld  input  1  operands valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B. Sampled with in_vld.
- out_vld  output  1  result valid this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB. For subtract, 1 = no borrow (A ≥ B unsigned).
- ovfl  output  1  signed overflow: operand signs (after B inversion for sub) equal and result sign differs.

## Operation

- Subtract implemented as A + ~B + 1. Inversion and carry-in of 1 applied when the operation enters stage 0.
- Stage k (0..STAGES−1) adds bit slice [k·SW +: SW] of A and (possibly inverted) B plus the carry registered from stage k−1. Stage 0 carry-in = sub.
- Each stage registers: its sum slice, its carry out, a valid bit, and the not-yet-consumed upper slices of A and effective B. Lower result slices are delayed alongside so all WIDTH bits emerge together.
- ovfl computed in the final stage from the MSB of the effective operands and the MSB of the sum.
- Data registers of a stage load only when that stage's incoming valid is 1. When valid is 0, data holds and the valid bit clears. Consequently sum/cout/ovfl hold the last valid result while out_vld = 0.
- No backpressure: a result is presented for exactly one cycle per accepted operation. The consumer must take it.
- Operations are independent. No state carries between operations other than the pipeline itself.
- STAGES = 1: single registered adder, latency 1.

## Timing

- Reset (rst_n low, asynchronous): all valid bits 0 immediately, so out_vld = 0. sum = 0, cout = 0, ovfl = 0. All internal data registers cleared.
- Reset released: first operation may be accepted on the first rising edge with rst_n high.
- Latency: in_vld = 1 sampled at edge n gives out_vld = 1 with the result for the interval after edge n+STAGES−1, i.e. STAGES cycles from input presentation to output.
- Throughput: one operation per cycle. Any in_vld pattern reappears on out_vld shifted by exactly STAGES cycles.
- Reset mid-operation: every in-flight operation is discarded. No out_vld pulse appears after rst_n deasserts unless a new operation is accepted.
- Carry crossing slice boundaries: full ripple, e.g. 0xFFFF+1, must propagate through all STAGES registered carries with no extra latency.
- A, B, sub are ignored when in_vld = 0.

## Test plan

(WIDTH=16, STAGES=4 unless noted)
- Add 0x00FF+0x0001, in_vld one cycle -> 4 cycles later out_vld=1 for one cycle, sum=0x0100, cout=0, ovfl=0. Outputs hold afterward with out_vld=0.
- Full carry ripple 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovfl=0. Also 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovfl=1.
- Subtract: 0x0005−0x0007 -> sum=0xFFFE, cout=0, ovfl=0. 0x8000−0x0001 -> sum=0x7FFF, cout=1, ovfl=1. 0x1234−0x1234 -> 0x0000, cout=1.
- Streaming: 10 back-to-back random ops with in_vld pattern 1101110111, mixed add/sub -> out_vld pattern identical, delayed 4. Each result matches the reference model in order.
- Reset with 3 ops in flight: rst_n low mid-cycle -> out_vld, sum, cout, ovfl go 0 without a clock edge. After release, no stray out_vld for 6 cycles.
- Parameter sweep: STAGES=1, WIDTH=8 (latency 1) and STAGES=8, WIDTH=8 (SW=1) with random vectors -> exact match and correct latency.
